// File: rtl/inst_fetch_buf_if.sv
// Instruction fetch buffer bus: PC-stage request, instruction ROM data, flush,
// and the decode-side handshake.
//   master: the environment (PC stage, ROM, decode); drives requests and ready.
//   slave : the fetch buffer; drives the decode-side outputs and the stall.
interface inst_fetch_buf_if;
  logic [31:0] pc_in;
  logic        ce_in;
  logic [31:0] inst_in;
  logic        flush_in;
  logic        id_ready_in;
  logic        id_valid_out;
  logic [31:0] id_pc_out;
  logic [31:0] id_inst_out;
  logic        stall_req_out;
  logic [1:0]  count_out;

  modport master (
    output pc_in, ce_in, inst_in, flush_in, id_ready_in,
    input  id_valid_out, id_pc_out, id_inst_out, stall_req_out, count_out
  );

  modport slave (
    input  pc_in, ce_in, inst_in, flush_in, id_ready_in,
    output id_valid_out, id_pc_out, id_inst_out, stall_req_out, count_out
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// Two-entry instruction fetch buffer between the PC stage / synchronous
// instruction ROM and the decode stage.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : inst_fetch_buf_if.slave
//         pc_in/ce_in   fetch request from the PC stage
//         inst_in       ROM data, valid the cycle after the request
//         flush_in      discard buffered and in-flight fetches
//         id_ready_in   decode consumes the head entry
//         id_valid_out/id_pc_out/id_inst_out  head entry (NOP_INST when empty)
//         stall_req_out PC stage must hold its pc
//         count_out     number of buffered entries (0..2)
module inst_fetch_buf #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  inst_fetch_buf_if.slave bus
);

  logic [1:0]  count_q, count_d;
  logic        req_valid_q;
  logic [31:0] req_pc_q;
  logic [31:0] pc_mem_q   [2];
  logic [31:0] inst_mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;

  logic        valid, pop, push, accept, stall;
  logic [2:0]  occupancy;

  always_comb begin
    valid     = (count_q != 2'd0);
    pop       = valid & bus.id_ready_in & ~bus.flush_in;
    push      = req_valid_q & ~bus.flush_in;
    // Entries that will be held after this edge, counting the fetch in flight.
    // pop implies count_q >= 1, so this cannot underflow.
    occupancy = {1'b0, count_q} + {2'b00, req_valid_q} - {2'b00, pop};
    stall     = ~bus.flush_in & (occupancy >= 3'd2);
    accept    = bus.ce_in & ~stall & ~bus.flush_in;
    if (bus.flush_in) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= 2'd0;
      req_valid_q   <= 1'b0;
      req_pc_q      <= 32'h0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      pc_mem_q[0]   <= 32'h0;
      pc_mem_q[1]   <= 32'h0;
      inst_mem_q[0] <= 32'h0;
      inst_mem_q[1] <= 32'h0;
    end else begin
      count_q     <= count_d;
      req_valid_q <= accept;
      if (accept) begin
        req_pc_q <= bus.pc_in;
      end
      if (bus.flush_in) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= req_pc_q;
          inst_mem_q[wr_ptr_q] <= bus.inst_in;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign bus.id_valid_out  = valid;
  assign bus.id_pc_out     = valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign bus.id_inst_out   = valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign bus.stall_req_out = stall;
  assign bus.count_out     = count_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
module tb_inst_fetch_buf;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] rom_q = 32'h0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_buf_if bus ();

  inst_fetch_buf #(.NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  // Synchronous ROM: data for the address presented at an edge is visible after it.
  always @(posedge clk) rom_q <= rom(bus.pc_in);
  assign bus.inst_in = rom_q;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_stall;
    logic [1:0]  exp_count;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic es, input logic [1:0] ec);
    chk({tag, " valid"}, {31'h0, bus.id_valid_out}, {31'h0, ev});
    chk({tag, " pc"},    bus.id_pc_out, ev ? epc : 32'h0);
    chk({tag, " inst"},  bus.id_inst_out, ev ? rom(epc) : NOP);
    chk({tag, " stall"}, {31'h0, bus.stall_req_out}, {31'h0, es});
    chk({tag, " count"}, {30'h0, bus.count_out}, {30'h0, ec});
  endtask

  // Drive inputs just after an edge, check at the falling edge, advance one edge.
  task automatic cycle(input string tag, input logic ce, input logic [31:0] pc,
                       input logic flush, input logic ready, input logic ev,
                       input logic [31:0] epc, input logic es, input logic [1:0] ec);
    bus.ce_in       = ce;
    bus.pc_in       = pc;
    bus.flush_in    = flush;
    bus.id_ready_in = ready;
    @(negedge clk);
    chk_out(tag, ev, epc, es, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ce_in       = 1'b0;
    bus.pc_in       = 32'h0;
    bus.flush_in    = 1'b0;
    bus.id_ready_in = 1'b0;

    // Streaming, ce gap, backpressure, simultaneous push/pop at count 1.
    vecs[0]  = '{1'b1, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 2'd0};
    vecs[1]  = '{1'b1, 32'd4,  1'b1, 1'b0, 32'd0,  1'b0, 2'd0};
    vecs[2]  = '{1'b1, 32'd8,  1'b1, 1'b1, 32'd0,  1'b0, 2'd1};
    vecs[3]  = '{1'b1, 32'd12, 1'b1, 1'b1, 32'd4,  1'b0, 2'd1};
    vecs[4]  = '{1'b0, 32'd16, 1'b1, 1'b1, 32'd8,  1'b0, 2'd1};
    vecs[5]  = '{1'b0, 32'd16, 1'b1, 1'b1, 32'd12, 1'b0, 2'd1};
    vecs[6]  = '{1'b0, 32'd16, 1'b1, 1'b0, 32'd0,  1'b0, 2'd0};
    vecs[7]  = '{1'b1, 32'd16, 1'b1, 1'b0, 32'd0,  1'b0, 2'd0};
    vecs[8]  = '{1'b1, 32'd20, 1'b1, 1'b0, 32'd0,  1'b0, 2'd0};
    vecs[9]  = '{1'b1, 32'd24, 1'b0, 1'b1, 32'd16, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 32'd24, 1'b0, 1'b1, 32'd16, 1'b1, 2'd2};
    vecs[11] = '{1'b1, 32'd24, 1'b1, 1'b1, 32'd16, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 32'd28, 1'b1, 1'b1, 32'd20, 1'b0, 2'd1};
    vecs[13] = '{1'b0, 32'd32, 1'b1, 1'b1, 32'd24, 1'b0, 2'd1};
    vecs[14] = '{1'b0, 32'd32, 1'b1, 1'b1, 32'd28, 1'b0, 2'd1};
    vecs[15] = '{1'b0, 32'd32, 1'b1, 1'b0, 32'd0,  1'b0, 2'd0};

    // Reset state.
    #12;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 2'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].ce, vecs[i].pc, 1'b0, vecs[i].ready,
            vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_stall, vecs[i].exp_count);
    end

    // Flush with a full buffer, then refetch from the branch target.
    cycle("fill_a",  1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("fill_b",  1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("fill_c",  1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 2'd1);
    cycle("full",    1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 2'd2);
    cycle("flush",   1'b1, 32'h40,  1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 2'd2);
    cycle("post_fl", 1'b1, 32'h40,  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("tgt_lat", 1'b0, 32'h44,  1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("tgt",     1'b0, 32'h44,  1'b0, 1'b1, 1'b1, 32'h40,  1'b0, 2'd1);

    // Flush with a fetch in flight: it must never land.
    cycle("if_req",  1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("if_fl",   1'b0, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("if_chk1", 1'b0, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("if_chk2", 1'b0, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);

    // Asynchronous reset mid-cycle with a full buffer.
    cycle("ar_a",    1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("ar_b",    1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("ar_c",    1'b1, 32'h308, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 2'd1);
    @(negedge clk);
    chk_out("ar_full", 1'b1, 32'h300, 1'b1, 2'd2);
    #2 rst = 1'b0;
    #1;
    chk_out("ar_async", 1'b0, 32'h0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    chk_out("ar_held", 1'b0, 32'h0, 1'b0, 2'd0);
    bus.ce_in       = 1'b1;
    bus.pc_in       = 32'h0;
    bus.id_ready_in = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("ar_lat",  1'b0, 32'h4,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 2'd0);
    cycle("ar_pc0",  1'b0, 32'h4,   1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 2'd1);
    cycle("ar_done", 1'b0, 32'h4,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
